// File: rtl/seq_alu_exec_if.sv
// Request/response bundle for the execute-stage ALU.
// Handshake rule, applies to both channels: a transfer happens on a rising
// clock edge where valid and ready are both high; the sender holds its
// payload stable while valid is high and ready is low.
interface seq_alu_exec_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_control;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             negative;
   logic             carry;
   logic             overflow;
   logic             illegal_op;

   // Producer of requests / consumer of results
   modport master (
      output in_valid, alu_control, src_a, src_b, flush, out_ready,
      input  in_ready, out_valid, result, zero, negative, carry, overflow, illegal_op
   );

   // The ALU itself
   modport slave (
      input  in_valid, alu_control, src_a, src_b, flush, out_ready,
      output in_ready, out_valid, result, zero, negative, carry, overflow, illegal_op
   );
endinterface

// File: rtl/seq_alu_exec.sv
// Execute-stage ALU. Single-cycle for everything except shifts, which walk
// one bit position per clock through a working register.
module seq_alu_exec #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic          clk,
   input  logic          reset,
   seq_alu_exec_if.slave bus,
   output logic [1:0]    state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_SLL  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd6;
   localparam logic [3:0] OP_XOR  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_SRA  = 4'd9;

   localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

   state_t             state_q, state_d;
   logic [3:0]         op_q;
   logic [WIDTH-1:0]   work_q;
   logic [SHAMT_W-1:0] count_q;
   logic [WIDTH-1:0]   result_q;
   logic               zero_q, negative_q, carry_q, overflow_q, illegal_q;

   logic               accept;
   logic               is_shift_in;
   logic [SHAMT_W-1:0] shamt_in;
   logic [WIDTH-1:0]   shift_next;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_carry, alu_ovf, alu_ill;
   logic [WIDTH:0]     sum_ext, diff_ext;

   assign shamt_in    = bus.src_b[SHAMT_W-1:0];
   assign is_shift_in = (bus.alu_control == OP_SLL) || (bus.alu_control == OP_SRL) ||
                        (bus.alu_control == OP_SRA);
   // A request colliding with flush is dropped, not accepted.
   assign accept      = (state_q == IDLE) && bus.in_valid && !bus.flush;
   assign state_dbg   = state_q;

   // State register: asynchronous reset straight to IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; flush overrides every transition.
   always_comb begin
      state_d = state_q;
      if (bus.flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (accept) state_d = (is_shift_in && shamt_in != '0) ? SHIFT : DONE;
            SHIFT:   if (count_q == CNT_ONE) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Handshake and result outputs, all driven from state and registers.
   always_comb begin
      bus.in_ready   = (state_q == IDLE);
      bus.out_valid  = (state_q == DONE);
      bus.result     = result_q;
      bus.zero       = zero_q;
      bus.negative   = negative_q;
      bus.carry      = carry_q;
      bus.overflow   = overflow_q;
      bus.illegal_op = illegal_q;
   end

   // Single-cycle ALU on the incoming operands. Subtract is a + ~b + 1 so
   // that bit WIDTH reads as "no borrow".
   always_comb begin
      sum_ext   = {1'b0, bus.src_a} + {1'b0, bus.src_b};
      diff_ext  = {1'b0, bus.src_a} + {1'b0, ~bus.src_b} + {{WIDTH{1'b0}}, 1'b1};
      alu_res   = '0;
      alu_carry = 1'b0;
      alu_ovf   = 1'b0;
      alu_ill   = 1'b0;
      case (bus.alu_control)
         OP_ADD: begin
            alu_res   = sum_ext[WIDTH-1:0];
            alu_carry = sum_ext[WIDTH];
            alu_ovf   = (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1]) &&
                        (sum_ext[WIDTH-1] != bus.src_a[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res   = diff_ext[WIDTH-1:0];
            alu_carry = diff_ext[WIDTH];
            alu_ovf   = (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1]) &&
                        (diff_ext[WIDTH-1] != bus.src_a[WIDTH-1]);
         end
         OP_AND:  alu_res = bus.src_a & bus.src_b;
         OP_OR:   alu_res = bus.src_a | bus.src_b;
         OP_XOR:  alu_res = bus.src_a ^ bus.src_b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.src_a < bus.src_b)};
         // Only zero-distance shifts take the single-cycle path.
         OP_SLL, OP_SRL, OP_SRA: alu_res = bus.src_a;
         default: alu_ill = 1'b1;
      endcase
   end

   // One-bit shift step of the working register.
   always_comb begin
      case (op_q)
         OP_SLL:  shift_next = {work_q[WIDTH-2:0], 1'b0};
         OP_SRA:  shift_next = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
         default: shift_next = {1'b0, work_q[WIDTH-1:1]};
      endcase
   end

   // Operand capture, shift iteration and result/flag registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q       <= '0;
         work_q     <= '0;
         count_q    <= '0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         negative_q <= 1'b0;
         carry_q    <= 1'b0;
         overflow_q <= 1'b0;
         illegal_q  <= 1'b0;
      end else if (!bus.flush) begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  op_q <= bus.alu_control;
                  if (is_shift_in && shamt_in != '0) begin
                     work_q  <= bus.src_a;
                     count_q <= shamt_in;
                  end else begin
                     result_q   <= alu_res;
                     zero_q     <= (alu_res == '0);
                     negative_q <= alu_res[WIDTH-1];
                     carry_q    <= alu_carry;
                     overflow_q <= alu_ovf;
                     illegal_q  <= alu_ill;
                  end
               end
            end
            SHIFT: begin
               work_q  <= shift_next;
               count_q <= count_q - CNT_ONE;
               if (count_q == CNT_ONE) begin
                  result_q   <= shift_next;
                  zero_q     <= (shift_next == '0);
                  negative_q <= shift_next[WIDTH-1];
                  carry_q    <= 1'b0;
                  overflow_q <= 1'b0;
                  illegal_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu_exec.sv
// Directed bench for seq_alu_exec: a table of single operations plus
// hand-written sequences for backpressure, flush and asynchronous reset.
module tb_seq_alu_exec;

   logic       clk;
   logic       reset;
   logic [1:0] state_dbg;
   int         errors;
   int         checks;

   seq_alu_exec_if #(.WIDTH(32)) bus ();

   seq_alu_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      logic        n;
      logic        c;
      logic        v;
      logic        il;
      int          lat;
   } vec_t;

   vec_t vq[$];

   // Clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic add_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic z,
                          input logic n, input logic c, input logic v, input logic il,
                          input int lat);
      vec_t t;
      t.name = name; t.op = op; t.a = a; t.b = b; t.res = res;
      t.z = z; t.n = n; t.c = c; t.v = v; t.il = il; t.lat = lat;
      vq.push_back(t);
   endtask

   // Issue one request, wait for the result, check it, then retire it.
   task automatic run_vec(input vec_t t);
      int lat;
      int w;
      @(negedge clk);
      w = 0;
      while (!bus.in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      check({t.name, " in_ready before issue"}, {31'd0, bus.in_ready}, 32'd1);
      bus.alu_control = t.op;
      bus.src_a       = t.a;
      bus.src_b       = t.b;
      bus.in_valid    = 1'b1;
      @(posedge clk);
      lat = 1;
      #1;
      bus.in_valid = 1'b0;
      bus.src_a    = 32'hDEAD_BEEF;
      bus.src_b    = 32'hFFFF_FFFF;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk);
         lat++;
         #1;
      end
      check({t.name, " latency"}, lat, t.lat);
      check({t.name, " result"}, bus.result, t.res);
      check({t.name, " zero"}, {31'd0, bus.zero}, {31'd0, t.z});
      check({t.name, " negative"}, {31'd0, bus.negative}, {31'd0, t.n});
      check({t.name, " carry"}, {31'd0, bus.carry}, {31'd0, t.c});
      check({t.name, " overflow"}, {31'd0, bus.overflow}, {31'd0, t.v});
      check({t.name, " illegal_op"}, {31'd0, bus.illegal_op}, {31'd0, t.il});
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check({t.name, " out_valid drop"}, {31'd0, bus.out_valid}, 32'd0);
      check({t.name, " in_ready return"}, {31'd0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      bit saw_valid;
      errors = 0;
      checks = 0;
      bus.in_valid    = 1'b0;
      bus.alu_control = 4'd0;
      bus.src_a       = '0;
      bus.src_b       = '0;
      bus.flush       = 1'b0;
      bus.out_ready   = 1'b0;
      reset           = 1'b1;

      //        name          op     a             b             res           z n c v il lat
      add_vec("add_ovf",     4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0,1,0,1,0, 1);
      add_vec("sub_eq",      4'd1,  32'd5,        32'd5,        32'h00000000, 1,0,1,0,0, 1);
      add_vec("slt",         4'd5,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0,0,0,0,0, 1);
      add_vec("sltu",        4'd6,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1,0,0,0,0, 1);
      add_vec("sra31",       4'd9,  32'h80000000, 32'd31,       32'hFFFFFFFF, 0,1,0,0,0, 32);
      add_vec("srl31",       4'd8,  32'h80000000, 32'd31,       32'h00000001, 0,0,0,0,0, 32);
      add_vec("sll0",        4'd4,  32'h00000001, 32'd0,        32'h00000001, 0,0,0,0,0, 1);
      add_vec("and",         4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0,1,0,0,0, 1);
      add_vec("or",          4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0,1,0,0,0, 1);
      add_vec("add_carry",   4'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1,0,1,0,0, 1);
      add_vec("sub_borrow",  4'd1,  32'd3,        32'd5,        32'hFFFFFFFE, 0,1,0,0,0, 1);
      add_vec("sub_ovf",     4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0,0,1,1,0, 1);
      add_vec("sll4_hib",    4'd4,  32'h00000003, 32'hFFFFFFE4, 32'h00000030, 0,0,0,0,0, 5);
      add_vec("sra3_pos",    4'd9,  32'h40000000, 32'd3,        32'h08000000, 0,0,0,0,0, 4);
      add_vec("illegal10",   4'd10, 32'h00001234, 32'h00000001, 32'h00000000, 1,0,0,0,1, 1);
      add_vec("illegal15",   4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1,0,0,0,1, 1);

      #22;
      reset = 1'b0;
      @(negedge clk);
      check("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset result", bus.result, 32'd0);
      check("reset flags", {27'd0, bus.zero, bus.negative, bus.carry, bus.overflow, bus.illegal_op}, 32'd0);

      foreach (vq[i]) run_vec(vq[i]);

      // Backpressure: result held stable while out_ready stays low.
      @(negedge clk);
      bus.alu_control = 4'd7;
      bus.src_a       = 32'hF0F0F0F0;
      bus.src_b       = 32'hFF00FF00;
      bus.in_valid    = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("bp out_valid latency1", {31'd0, bus.out_valid}, 32'd1);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check("bp result held", bus.result, 32'h0FF00FF0);
         check("bp out_valid held", {31'd0, bus.out_valid}, 32'd1);
         check("bp in_ready low", {31'd0, bus.in_ready}, 32'd0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      check("bp out_valid drop", {31'd0, bus.out_valid}, 32'd0);
      check("bp in_ready return", {31'd0, bus.in_ready}, 32'd1);

      // Request in the same cycle as flush is not accepted.
      @(negedge clk);
      bus.alu_control = 4'd0;
      bus.src_a       = 32'd1;
      bus.src_b       = 32'd1;
      bus.in_valid    = 1'b1;
      bus.flush       = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      check("flush_req state idle", {30'd0, state_dbg}, 32'd0);
      @(posedge clk);
      #1;
      check("flush_req no out_valid", {31'd0, bus.out_valid}, 32'd0);

      // Flush in the third SHIFT cycle of sll by 10.
      @(negedge clk);
      bus.alu_control = 4'd4;
      bus.src_a       = 32'd1;
      bus.src_b       = 32'd10;
      bus.in_valid    = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("flush shift entered", {30'd0, state_dbg}, 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      check("flush idle next", {30'd0, state_dbg}, 32'd0);
      check("flush in_ready", {31'd0, bus.in_ready}, 32'd1);
      saw_valid = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) saw_valid = 1'b1;
      end
      check("flush no out_valid ever", {31'd0, saw_valid}, 32'd0);
      add_vec("post_flush_add", 4'd0, 32'd2, 32'd3, 32'd5, 0,0,0,0,0, 1);
      run_vec(vq[vq.size()-1]);

      // Asynchronous reset in the middle of a shift, away from any clock edge.
      @(negedge clk);
      bus.alu_control = 4'd4;
      bus.src_a       = 32'd1;
      bus.src_b       = 32'd20;
      bus.in_valid    = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      check("areset pre in_ready", {31'd0, bus.in_ready}, 32'd0);
      reset = 1'b1;
      #1;
      check("areset out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("areset in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("areset result", bus.result, 32'd0);
      #1;
      reset = 1'b0;
      add_vec("post_reset_illegal12", 4'd12, 32'h00000055, 32'h00000077, 32'd0, 1,0,0,0,1, 1);
      run_vec(vq[vq.size()-1]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
